// File: rtl/arb_pkg.sv
// Shared types and constants for the 16-requester round-robin arbiter.
package arb_pkg;

  localparam int N     = 16;
  localparam int SEL_W = 4;

  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [N-1:0] onehot_t;

  function automatic onehot_t onehot(input logic [SEL_W-1:0] idx);
    onehot_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] sel
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    dbl = {req, req};
    // Bit 0 of rot is requester ptr; the doubled vector makes the wrap free.
    rot = dbl[ptr +: N];
    off = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && !any) begin
        any = 1'b1;
        off = SEL_W'(i);
      end
    end
    sel = ptr + off;
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter, 16 requesters, registered one-hot grant with hold timeout.
module rr_arbiter16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic        en,
  output logic        timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  onehot_t          gnt_d;
  logic             en_d, tmo_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_sel;
  logic             rel_done, rel_wd, rel_to;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .sel (pick_sel)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    hold_d   = hold_q;
    gnt_d    = gnt;
    en_d     = en;
    tmo_d    = 1'b0;
    rel_done = done;
    rel_wd   = !req[sel_q];
    rel_to   = (hold_q == HOLD_LAST);
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = pick_sel;
          gnt_d   = onehot(pick_sel);
          en_d    = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (rel_done || rel_wd || rel_to) begin
          state_d = IDLE;
          gnt_d   = '0;
          en_d    = 1'b0;
          ptr_d   = sel_q + 4'd1;
          tmo_d   = rel_to && !rel_done && !rel_wd;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      gnt     <= '0;
      en      <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      gnt     <= gnt_d;
      en      <= en_d;
      timeout <= tmo_d;
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt));
  a_en_matches:  assert property (@(posedge clk) en == (|gnt));

endmodule
